mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// CPU memory/I-O responder: byte RAM, console input port, buffered console
// output queue, free-running cycle counter with snapshot, and program-stop.
module mem_io_responder #(
    parameter int RAM_AW    = 17,
    parameter int TXQ_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);

    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] TXQ_FULL = CW'(TXQ_DEPTH);

    typedef enum logic [2:0] {
        IO_DATA,   // 0x30000: rx read / tx write
        IO_CNT0,   // 0x30004: counter byte 0 read / stop write
        IO_SNAP1,  // 0x30005
        IO_SNAP2,  // 0x30006
        IO_SNAP3,  // 0x30007
        IO_NONE
    } io_reg_e;

    // Storage arrays.
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] txq_mem [TXQ_DEPTH];

    // Registered state.
    logic [31:0]   cnt_q, cnt_d;
    logic [23:0]   snap_q, snap_d;          // counter bytes 3..1; byte 0 is returned live
    logic          stop_pending_q, stop_pending_d;
    logic          prog_stop_q, prog_stop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [7:0]    io_rd_q, io_rd_d;
    logic          rd_src_ram_q, rd_src_ram_d;
    logic [7:0]    ram_rd_q;

    // Decode and handshake signals.
    io_reg_e           io_reg;
    logic              is_io;
    logic              rx_rd;
    logic              tx_push_req;
    logic              txq_full;
    logic              txq_empty;
    logic              stall;
    logic              accept;
    logic              push;
    logic              pop;
    logic [7:0]        push_byte;
    logic              ram_we;
    logic              ram_re;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^mem_a[31:18];

    assign is_io     = (mem_a[17:16] == 2'b11);
    assign ram_idx   = mem_a[RAM_AW-1:0];
    assign txq_full  = (occ_q == TXQ_FULL);
    assign txq_empty = (occ_q == '0);

    // Map the low address bits of an I/O access onto a register.
    always_comb begin
        io_reg = IO_NONE;
        case (mem_a[15:0])
            16'h0000: io_reg = IO_DATA;
            16'h0004: io_reg = IO_CNT0;
            16'h0005: io_reg = IO_SNAP1;
            16'h0006: io_reg = IO_SNAP2;
            16'h0007: io_reg = IO_SNAP3;
            default:  io_reg = IO_NONE;
        endcase
    end

    assign rx_rd       = is_io && !mem_wr && (io_reg == IO_DATA);
    // Once a stop is pending every I/O write is dropped, so it never needs a push.
    assign tx_push_req = is_io && mem_wr && !stop_pending_q &&
                         (((io_reg == IO_DATA) && (mem_dout != 8'h00)) || (io_reg == IO_CNT0));
    assign push_byte   = (io_reg == IO_CNT0) ? 8'h00 : mem_dout;

    // The queue-full stall keys off registered occupancy, so a pop in the same
    // cycle does not release it; the push lands the cycle after.
    assign stall    = (rx_rd && !rx_valid) || (tx_push_req && txq_full);
    assign rdy_out  = rst_in && !stall;
    assign accept   = rdy_out;
    assign rx_ready = rst_in && rx_rd && rx_valid;

    assign push   = accept && tx_push_req;
    assign pop    = tx_valid && tx_ready;
    assign ram_we = accept && !is_io && mem_wr;
    assign ram_re = accept && !is_io && !mem_wr;

    assign tx_valid  = !txq_empty;
    assign tx_data   = txq_mem[rd_ptr_q];
    assign prog_stop = prog_stop_q;
    assign mem_din   = rd_src_ram_q ? ram_rd_q : io_rd_q;

    // Next-state logic for counter, snapshot, stop, queue bookkeeping and read data.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
        cnt_d          = cnt_q + 32'd1;
        snap_d         = snap_q;
        stop_pending_d = stop_pending_q;
        prog_stop_d    = prog_stop_q | (stop_pending_q & txq_empty);
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        io_rd_d        = io_rd_q;
        rd_src_ram_d   = rd_src_ram_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if (push && (io_reg == IO_CNT0)) begin
            stop_pending_d = 1'b1;
        end

        if (accept && !mem_wr) begin
            rd_src_ram_d = !is_io;
            if (is_io) begin
                case (io_reg)
                    IO_DATA:  io_rd_d = rx_data;
                    IO_CNT0: begin
                        io_rd_d = cnt_q[7:0];
                        snap_d  = cnt_q[31:8];
                    end
                    IO_SNAP1: io_rd_d = snap_q[7:0];
                    IO_SNAP2: io_rd_d = snap_q[15:8];
                    IO_SNAP3: io_rd_d = snap_q[23:16];
                    default:  io_rd_d = 8'h00;
                endcase
            end
        end
    end

    // State register; reset clears everything except the storage arrays.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q          <= '0;
            snap_q         <= '0;
            stop_pending_q <= 1'b0;
            prog_stop_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            io_rd_q        <= 8'h00;
            rd_src_ram_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            stop_pending_q <= stop_pending_d;
            prog_stop_q    <= prog_stop_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            io_rd_q        <= io_rd_d;
            rd_src_ram_q   <= rd_src_ram_d;
        end
    end

    // RAM with synchronous write and registered read; a write is visible to the next read.
    always_ff @(posedge clk_in) begin
        // NOTE: memories carry no reset so they map onto block RAM; reset selects the I/O read path instead.
        if (ram_we) begin
            ram[ram_idx] <= mem_dout;
        end
        if (ram_re) begin
            ram_rd_q <= ram[ram_idx];
        end
    end

    // TX queue storage; validity is tracked by pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (push) begin
            txq_mem[wr_ptr_q] <= push_byte;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder with read-data and TX scoreboards.
module tb_mem_io_responder;

    localparam int STALL_MAX = 20;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] cyc_model;
    logic [31:0] snap_model;

    mem_io_responder #(.RAM_AW(17), .TXQ_DEPTH(8)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .rdy_out   (rdy_out),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .prog_stop (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle count: zero in reset, +1 per clock.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cyc_model <= 32'd0;
        else         cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // TX monitor: each handshake must deliver the oldest expected byte.
    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) check("tx_unexpected_pop", tx_data, 32'h100);
            else                    check("tx_order", tx_data, tx_exp.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        mem_a    = 32'h0003_000C;   // write to an unused I/O address: no effect
        mem_wr   = 1'b1;
        mem_dout = 8'h00;
    endtask

    // One bus access starting just after a rising edge; returns the stall count.
    task automatic bus_op(input string tag, input logic [31:0] a, input logic wr,
                          input logic [7:0] d, input logic [7:0] exp_rd,
                          input logic snap_rd, output int stalls);
        stalls   = 0;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(negedge clk_in);
        while (!rdy_out && stalls < STALL_MAX) begin
            stalls++;
            @(negedge clk_in);
        end
        if (!rdy_out) begin
            check({tag, "_timeout"}, rdy_out, 1);
            @(posedge clk_in); #1;
            drive_idle();
            return;
        end
        if (!wr) begin
            if (snap_rd) begin
                snap_model = cyc_model;
                rd_exp.push_back(cyc_model[7:0]);
            end else begin
                rd_exp.push_back(exp_rd);
            end
        end
        @(posedge clk_in); #1;
        drive_idle();
        if (!wr) begin
            @(negedge clk_in);
            check(tag, mem_din, rd_exp.pop_front());
            @(posedge clk_in); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        tx_ready = 1'b1;
        while (tx_exp.size() != 0 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_left"}, tx_exp.size(), 0);
        @(negedge clk_in);
        check({tag, "_empty"}, tx_valid, 0);
        @(posedge clk_in); #1;
    endtask

    initial begin
        int st;
        int n;

        // Reset state, with an input byte offered to prove gating.
        rst_in   = 1'b0;
        mem_a    = 32'h0003_0000;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_mem_din",   mem_din,   8'h00);
        check("rst_rdy_out",   rdy_out,   0);
        check("rst_rx_ready",  rx_ready,  0);
        check("rst_tx_valid",  tx_valid,  0);
        check("rst_prog_stop", prog_stop, 0);
        @(posedge clk_in); #1;
        rx_valid = 1'b0;
        rst_in   = 1'b1;

        // RAM basics, first access right after reset release.
        bus_op("ram_wr_a5", 32'h0000_0010, 1'b1, 8'hA5, 8'h00, 1'b0, st);
        check("first_access_no_stall", st, 0);
        bus_op("ram_rd_a5", 32'h0000_0010, 1'b0, 8'h00, 8'hA5, 1'b0, st);
        bus_op("ram_wr_top", 32'h0001_FFFF, 1'b1, 8'h5A, 8'h00, 1'b0, st);
        bus_op("ram_rd_after_wr", 32'h0001_FFFF, 1'b0, 8'h00, 8'h5A, 1'b0, st);
        bus_op("ram_alias_0x20010", 32'h0002_0010, 1'b0, 8'h00, 8'hA5, 1'b0, st);
        bus_op("io_other_0x30008", 32'h0003_0008, 1'b0, 8'h00, 8'h00, 1'b0, st);
        bus_op("io_other_0x3ffff", 32'h0003_FFFF, 1'b0, 8'h00, 8'h00, 1'b0, st);

        // Input port: three stalled cycles, then one-cycle handshake.
        mem_a = 32'h0003_0000; mem_wr = 1'b0; rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("rx_stall", rdy_out, 0);
            check("rx_ready_wait", rx_ready, 0);
            @(posedge clk_in); #1;
        end
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk_in);
        check("rx_accept", rdy_out, 1);
        check("rx_ready_pulse", rx_ready, 1);
        rd_exp.push_back(8'h41);
        @(posedge clk_in); #1;
        drive_idle(); rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk_in);
        check("rx_ready_drop", rx_ready, 0);
        check("rx_data_read", mem_din, rd_exp.pop_front());
        @(posedge clk_in); #1;

        // Zero bytes are filtered out of the TX stream.
        tx_ready = 1'b0;
        bus_op("tx_zero_wr", 32'h0003_0000, 1'b1, 8'h00, 8'h00, 1'b0, st);
        repeat (2) @(negedge clk_in);
        check("tx_zero_filtered", tx_valid, 0);
        @(posedge clk_in); #1;

        // Backpressure: eight bytes fill the queue, the ninth stalls.
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(8'h31 + 8'(i));
            bus_op("bp_wr", 32'h0003_0000, 1'b1, 8'h31 + 8'(i), 8'h00, 1'b0, st);
            check("bp_no_stall", st, 0);
        end
        tx_exp.push_back(8'h39);
        mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'h39;
        @(negedge clk_in);
        check("bp_full_stall", rdy_out, 0);
        @(negedge clk_in);
        check("bp_full_stall2", rdy_out, 0);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        @(negedge clk_in);
        check("bp_stall_during_pop", rdy_out, 0);
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("bp_accept_after_pop", rdy_out, 1);
        @(posedge clk_in); #1;
        drive_idle();
        drain("bp_drain");

        // Counter and snapshot.
        while (cyc_model < 32'd300) @(posedge clk_in);
        #1;
        bus_op("cnt_byte0", 32'h0003_0004, 1'b0, 8'h00, 8'h00, 1'b1, st);
        bus_op("snap_byte1", 32'h0003_0005, 1'b0, 8'h00, snap_model[15:8],  1'b0, st);
        bus_op("snap_byte2", 32'h0003_0006, 1'b0, 8'h00, snap_model[23:16], 1'b0, st);
        bus_op("snap_byte3", 32'h0003_0007, 1'b0, 8'h00, snap_model[31:24], 1'b0, st);

        // Asynchronous reset in the middle of queued output and a pending stall.
        tx_ready = 1'b0;
        bus_op("pre_rst_wr1", 32'h0003_0000, 1'b1, 8'h71, 8'h00, 1'b0, st);
        bus_op("pre_rst_wr2", 32'h0003_0000, 1'b1, 8'h72, 8'h00, 1'b0, st);
        mem_a = 32'h0003_0000; mem_wr = 1'b0; rx_valid = 1'b0;
        @(negedge clk_in);
        check("pre_rst_stall", rdy_out, 0);
        #2;
        rst_in = 1'b0;
        rx_valid = 1'b1;
        #1;
        check("midrst_tx_valid",  tx_valid,  0);
        check("midrst_rdy_out",   rdy_out,   0);
        check("midrst_rx_ready",  rx_ready,  0);
        check("midrst_mem_din",   mem_din,   8'h00);
        check("midrst_prog_stop", prog_stop, 0);
        @(posedge clk_in); #1;
        rx_valid = 1'b0;
        mem_a = 32'h0000_0010;
        rst_in = 1'b1;
        bus_op("ram_kept_over_rst", 32'h0000_0010, 1'b0, 8'h00, 8'hA5, 1'b0, st);
        check("rst_first_access_no_stall", st, 0);
        bus_op("cnt_after_rst", 32'h0003_0004, 1'b0, 8'h00, 8'h00, 1'b1, st);
        bus_op("snap1_after_rst", 32'h0003_0005, 1'b0, 8'h00, snap_model[15:8], 1'b0, st);

        // Stop: two bytes queued, then the stop write with the sink ready.
        tx_exp.push_back(8'h61);
        bus_op("stop_wr1", 32'h0003_0000, 1'b1, 8'h61, 8'h00, 1'b0, st);
        tx_exp.push_back(8'h62);
        bus_op("stop_wr2", 32'h0003_0000, 1'b1, 8'h62, 8'h00, 1'b0, st);
        tx_ready = 1'b1;
        tx_exp.push_back(8'h00);
        bus_op("stop_wr", 32'h0003_0004, 1'b1, 8'h00, 8'h00, 1'b0, st);
        n = 0;
        @(negedge clk_in);
        while (tx_valid && n < 20) begin
            n++;
            @(negedge clk_in);
        end
        check("stop_queue_emptied", tx_valid, 0);
        check("stop_all_drained", tx_exp.size(), 0);
        check("stop_low_when_empty", prog_stop, 0);
        @(negedge clk_in);
        check("stop_rises_after_empty", prog_stop, 1);
        @(posedge clk_in); #1;

        // After stop: I/O writes ignored, RAM still served, stop is sticky.
        bus_op("post_stop_wr", 32'h0003_0000, 1'b1, 8'h42, 8'h00, 1'b0, st);
        check("post_stop_no_stall", st, 0);
        repeat (3) @(negedge clk_in);
        check("post_stop_no_tx", tx_valid, 0);
        @(posedge clk_in); #1;
        bus_op("post_stop_ram_wr", 32'h0000_0123, 1'b1, 8'hC3, 8'h00, 1'b0, st);
        bus_op("post_stop_ram_rd", 32'h0000_0123, 1'b0, 8'h00, 8'hC3, 1'b0, st);
        check("prog_stop_sticky", prog_stop, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
